// File: rtl/ternary_to_binary_seq_pkg.sv
// Shared definitions for the 2-bit-per-trit ternary encoding and the
// conversion FSM states used by the ternary/binary converters.
package ternary_to_binary_seq_pkg;

  localparam logic [1:0] TRIT_0   = 2'b00;
  localparam logic [1:0] TRIT_1   = 2'b01;
  localparam logic [1:0] TRIT_2   = 2'b10;
  localparam logic [1:0] TRIT_BAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } convState_t;

  // 3^n as a constant function, used to size-check binary result widths.
  function automatic longint unsigned pow3(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) begin
      p = p * 3;
    end
    return p;
  endfunction

endpackage

// File: rtl/ternary_to_binary_seq_tern_mac3.sv
// One Horner step for base 3: acc_out = 3*acc_in + trit, with an invalid
// trit contributing zero and raising err_out.
module tern_mac3
  import ternary_to_binary_seq_pkg::*;
#(
  parameter int BW = 7
) (
  input  logic [BW-1:0] acc_in,
  input  logic [1:0]    trit,
  output logic [BW-1:0] acc_out,
  output logic          err_out
);

  logic [BW-1:0] w_tritVal;

  always_comb begin
    w_tritVal = '0;
    err_out   = 1'b0;
    case (trit)
      TRIT_0:   w_tritVal = BW'(0);
      TRIT_1:   w_tritVal = BW'(1);
      TRIT_2:   w_tritVal = BW'(2);
      default: begin
        w_tritVal = '0;
        err_out   = 1'b1;
      end
    endcase
  end

  assign acc_out = (acc_in << 1) + acc_in + w_tritVal;

endmodule

// File: rtl/ternary_to_binary_seq.sv
// Digit-serial ternary-to-binary decoder: accepts one NTRITS-trit word and
// folds it into binary MSB trit first, one trit per clock.
module ternary_to_binary_seq
  import ternary_to_binary_seq_pkg::*;
#(
  parameter int NTRITS = 4,
  parameter int BW     = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*NTRITS-1:0]   in_trits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BW-1:0]         out_bin,
  output logic                  out_err
);

  localparam int CW = (NTRITS > 1) ? $clog2(NTRITS) : 1;

  if (pow3(NTRITS) > (64'd1 << BW)) begin : g_bwCheck
    $error("ternary_to_binary_seq: BW too narrow to hold 3^NTRITS - 1");
  end

  convState_t          r_state;
  convState_t          w_nextState;
  logic                r_armed;
  logic [2*NTRITS-1:0] r_word;
  logic [BW-1:0]       r_acc;
  logic                r_err;
  logic [CW-1:0]       r_cnt;
  logic [BW-1:0]       r_outBin;
  logic                r_outErr;
  logic                r_outValid;

  logic                w_inReady;
  logic                w_accept;
  logic                w_convLast;
  logic                w_release;
  logic [1:0]          w_trit;
  logic [BW-1:0]       w_macAcc;
  logic                w_macErr;

  assign w_trit = r_word[{r_cnt, 1'b0} +: 2];

  tern_mac3 #(
    .BW(BW)
  ) u_mac (
    .acc_in (r_acc),
    .trit   (w_trit),
    .acc_out(w_macAcc),
    .err_out(w_macErr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Encodings outside the enum fall to the default arm and recover to IDLE.
  always_comb begin
    w_nextState = IDLE;
    case (r_state)
      IDLE:    w_nextState = w_accept ? CONV : IDLE;
      CONV:    w_nextState = w_convLast ? DONE : CONV;
      DONE:    w_nextState = w_release ? IDLE : DONE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_inReady  = 1'b0;
    w_accept   = 1'b0;
    w_convLast = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = r_armed;
        w_accept  = r_armed && in_valid;
      end
      CONV: begin
        w_convLast = (r_cnt == '0);
      end
      DONE: begin
        w_release = r_outValid && out_ready;
      end
      default: begin
        w_inReady = 1'b0;
      end
    endcase
  end

  // Keeps in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= '0;
      r_acc  <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_word <= in_trits;
      r_acc  <= '0;
      r_err  <= 1'b0;
      r_cnt  <= CW'(NTRITS - 1);
    end else if (r_state == CONV) begin
      r_acc  <= w_macAcc;
      r_err  <= r_err | w_macErr;
      r_cnt  <= r_cnt - CW'(1);
    end
  end

  // Result registers hold their value after the handshake until the next word completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outBin   <= '0;
      r_outErr   <= 1'b0;
      r_outValid <= 1'b0;
    end else if (w_convLast) begin
      r_outBin   <= w_macAcc;
      r_outErr   <= r_err | w_macErr;
      r_outValid <= 1'b1;
    end else if (w_release || (r_state != DONE)) begin
      r_outValid <= 1'b0;
    end
  end

  assign in_ready  = w_inReady;
  assign out_valid = r_outValid;
  assign out_bin   = r_outBin;
  assign out_err   = r_outErr;

endmodule
